// File: rtl/alu_uart_tx.sv
// alu_uart_tx: serializes a 32-bit ALU result as four back-to-back UART frames.
// Byte 0 (data[7:0]) goes first. Each bit is held for CLKS_PER_BIT cycles.
// Optional feature macro: UART_PARITY_EN.
//   Undefined: 8N1 frames, 40 bit times per word.
//   Defined:   8E1 frames (even parity before stop), 44 bit times per word.
module alu_uart_tx #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] data,
  output logic        busy,
  output logic        done,
  output logic        tx
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TMAX = CW'(CLKS_PER_BIT - 1);

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] timer_q, timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [31:0]   shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          bit_end;
`ifdef UART_PARITY_EN
  logic          par_q, par_d;
`endif

  assign bit_end = (timer_q == TMAX);
  assign tx      = tx_q;
  assign busy    = busy_q;
  assign done    = done_q;

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef UART_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef UART_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  // Next-state logic. tx_d always carries the value of the bit being entered,
  // so tx changes on the same edge as the state. Each data bit is shifted out
  // of shift_q at the moment it is loaded onto tx.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
`ifdef UART_PARITY_EN
    par_d      = par_q;
`endif

    if (state_q != IDLE) begin
      timer_d = bit_end ? '0 : timer_q + CW'(1);
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = START;
          shift_d    = data;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
          timer_d    = '0;
          bit_idx_d  = '0;
          byte_idx_d = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[31:1]};
`ifdef UART_PARITY_EN
          par_d   = shift_q[0];
`endif
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = '0;
`ifdef UART_PARITY_EN
            // par_q already holds the XOR of all eight data bits.
            state_d   = PARITY;
            tx_d      = par_q;
`else
            state_d   = STOP;
            tx_d      = 1'b1;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[0];
            shift_d   = {1'b0, shift_q[31:1]};
`ifdef UART_PARITY_EN
            par_d     = par_q ^ shift_q[0];
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (byte_idx_q == 2'd3) begin
            state_d    = IDLE;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            tx_d       = 1'b1;
            byte_idx_d = '0;
          end else begin
            state_d    = START;
            tx_d       = 1'b0;
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_uart_tx.sv
// Testbench for alu_uart_tx with CLKS_PER_BIT=4. The bench queues the expected
// bytes when it launches a word and compares them against the frames it
// decodes from tx.
module tb_alu_uart_tx;

  localparam int C = 4;
`ifdef UART_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int WB = 4 * FB;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] data;
  logic        busy;
  logic        done;
  logic        tx;

  int checks = 0;
  int errors = 0;
  logic [7:0] sbq[$];

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [7:0]  b3;
  } vec_t;

  vec_t vecs [0:4];

  alu_uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .data  (data),
    .busy  (busy),
    .done  (done),
    .tx    (tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Launch one word and follow it to the done pulse.
  // mode 0: start pulsed once; mode 1: extra start pulse at busy cycle 80;
  // mode 2: start held high with data changing every cycle.
  task automatic send_word(input logic [31:0] d, input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3, input int mode);
    logic       bits [0:WB-1];
    logic [7:0] got;
    logic [7:0] want;
    int         cyc;
    sbq.push_back(e0);
    sbq.push_back(e1);
    sbq.push_back(e2);
    sbq.push_back(e3);
    data  = d;
    start = 1'b1;
    @(posedge clk); #1;
    for (int b = 0; b < WB; b++) begin
      for (int c = 0; c < C; c++) begin
        cyc = b * C + c;
        start = (mode == 2) || (mode == 1 && cyc == 80);
        data  = $urandom;
        if (c == 0) bits[b] = tx;
        else chk("tx_stable", tx, bits[b]);
        chk("busy_high", busy, 1);
        chk("done_low", done, 0);
        @(posedge clk); #1;
      end
    end
    chk("busy_fall", busy, 0);
    chk("done_pulse", done, 1);
    chk("tx_idle_after", tx, 1);
    for (int f = 0; f < 4; f++) begin
      chk("start_bit", bits[f*FB], 0);
      for (int i = 0; i < 8; i++) got[i] = bits[f*FB + 1 + i];
      if (sbq.size() == 0) begin
        chk("sb_empty", 1, 0);
      end else begin
        want = sbq.pop_front();
        chk("byte", got, want);
`ifdef UART_PARITY_EN
        chk("parity", bits[f*FB + 9], ^want);
`endif
      end
      chk("stop_bit", bits[f*FB + FB - 1], 1);
    end
    if (mode != 2) begin
      start = 1'b0;
      @(posedge clk); #1;
      chk("done_one_cycle", done, 0);
      chk("busy_stays_low", busy, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{data: 32'h0000_0005, b0: 8'h05, b1: 8'h00, b2: 8'h00, b3: 8'h00};
    vecs[1] = '{data: 32'hA5C3_0F81, b0: 8'h81, b1: 8'h0F, b2: 8'hC3, b3: 8'hA5};
    vecs[2] = '{data: 32'h0000_0007, b0: 8'h07, b1: 8'h00, b2: 8'h00, b3: 8'h00};
    vecs[3] = '{data: 32'h1234_5678, b0: 8'h78, b1: 8'h56, b2: 8'h34, b3: 8'h12};
    vecs[4] = '{data: 32'hFFFF_FFFF, b0: 8'hFF, b1: 8'hFF, b2: 8'hFF, b3: 8'hFF};

    reset = 1'b1;
    start = 1'b0;
    data  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;

    // Table of words, each sent with a single start pulse.
    for (int v = 0; v < 5; v++) begin
      send_word(vecs[v].data, vecs[v].b0, vecs[v].b1, vecs[v].b2, vecs[v].b3, 0);
    end

    // Start pulse while busy must be ignored.
    send_word(32'h0000_0005, 8'h05, 8'h00, 8'h00, 8'h00, 1);

    // Start held high: only the accepted value goes out, next word follows done.
    send_word(32'hDEAD_BEEF, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 2);
    send_word(32'h0BAD_F00D, 8'h0D, 8'hF0, 8'hAD, 8'h0B, 0);

    // Reset about 50 cycles into a word aborts it immediately.
    data  = 32'h5555_AAAA;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (49) @(posedge clk);
    #1;
    chk("pre_abort_busy", busy, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_tx", tx, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("abort_hold_done", done, 0);
    end
    reset = 1'b0;
    for (int i = 0; i < 3 * FB * C; i++) begin
      @(posedge clk); #1;
      chk("post_abort_tx", tx, 1);
      chk("post_abort_busy", busy, 0);
      chk("post_abort_done", done, 0);
    end
    send_word(vecs[1].data, vecs[1].b0, vecs[1].b1, vecs[1].b2, vecs[1].b3, 0);

    chk("sb_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
